// File: rtl/if_stage_pkg.sv
// Shared CPU-wide definitions for the fetch stage: bus widths, reset PC and bus layouts.
package if_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;
  localparam logic [31:0] RESET_PC        = 32'h1BFF_FFFC;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage over a req/addr_ok/data_ok SRAM-like bus with branch cancel tracking.
// Optional delivered-instruction counter enabled by defining FS_PERF_CNT_EN.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata,
  output logic [31:0]                fs_inst_cnt
);

  br_bus_t     br;
  fs_to_ds_t   fs_out;
  logic        fs_valid, inst_buf_valid, br_buf_valid;
  logic [1:0]  cancel_cnt;
  logic [31:0] fs_pc, inst_buf, br_buf_target, nextpc;
  logic        data_live, fs_ready_go, fs_allowin, accept, handoff, capture;
  logic        cancel_inc, cancel_dec;

  assign br = br_bus;

  assign nextpc = br_buf_valid ? br_buf_target :
                  br.taken     ? br.target     : fs_pc + 32'd4;

  // Returned data belongs to fs only once all cancelled responses have drained.
  assign data_live   = inst_sram_data_ok & (cancel_cnt == 2'd0);
  assign fs_ready_go = inst_buf_valid | data_live;
  assign fs_allowin  = !fs_valid | (fs_ready_go & ds_allowin) | br.taken;

  assign inst_sram_req  = !reset & fs_allowin;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'd2;
  assign inst_sram_addr = nextpc;
  assign accept         = inst_sram_req & inst_sram_addr_ok;

  assign fs_to_ds_valid = !reset & fs_valid & fs_ready_go & !br.taken;
  assign handoff        = fs_to_ds_valid & ds_allowin;
  assign capture        = data_live & fs_valid & !ds_allowin & !br.taken;

  assign cancel_inc = br.taken & fs_valid & !fs_ready_go;
  assign cancel_dec = inst_sram_data_ok & (cancel_cnt != 2'd0);

  assign fs_out.inst  = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_out.pc    = fs_pc;
  assign fs_to_ds_bus = fs_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC;
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'd0;
      br_buf_valid   <= 1'b0;
      br_buf_target  <= 32'd0;
      cancel_cnt     <= 2'd0;
    end else begin
      // A newly accepted address wins over any clear in the same cycle.
      if (accept) begin
        fs_valid <= 1'b1;
        fs_pc    <= nextpc;
      end else if (br.taken | handoff) begin
        fs_valid <= 1'b0;
      end

      if (accept | br.taken | handoff) inst_buf_valid <= 1'b0;
      else if (capture)                inst_buf_valid <= 1'b1;
      if (capture) inst_buf <= inst_sram_rdata;

      if (accept) begin
        br_buf_valid <= 1'b0;
      end else if (br.taken) begin
        br_buf_valid  <= 1'b1;
        br_buf_target <= br.target;
      end

      case ({cancel_inc, cancel_dec})
        2'b10:   cancel_cnt <= cancel_cnt + 2'd1;
        2'b01:   cancel_cnt <= cancel_cnt - 2'd1;
        default: cancel_cnt <= cancel_cnt;
      endcase
    end
  end

`ifdef FS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)        fs_inst_cnt <= 32'd0;
    else if (handoff) fs_inst_cnt <= fs_inst_cnt + 32'd1;
  end
`else
  assign fs_inst_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order SRAM responder model.
module tb_if_stage;

  logic        clk, reset, ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [31:0] fs_inst_cnt;

  logic        addr_ok, data_en, force_dok;
  logic [31:0] fifo [0:7];
  logic [2:0]  wp, rp;
  logic        real_dok;
  int          tests, failed;

  if_stage dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .fs_inst_cnt(fs_inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: returns data in order; 1C000008 holds 02800421, others return addr ^ FFFF0000.
  assign inst_sram_addr_ok = addr_ok;
  assign real_dok          = data_en & (wp != rp);
  assign inst_sram_data_ok = force_dok | real_dok;
  assign inst_sram_rdata   = force_dok ? 32'hDEADBEEF :
                             (fifo[rp] == 32'h1C000008) ? 32'h02800421 : (fifo[rp] ^ 32'hFFFF0000);

  always @(posedge clk) begin
    if (reset) begin
      wp <= 3'd0;
      rp <= 3'd0;
    end else begin
      if (real_dok) rp <= rp + 3'd1;
      if (inst_sram_req && inst_sram_addr_ok) begin
        fifo[wp] <= inst_sram_addr;
        wp       <= wp + 3'd1;
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; ds_allowin = 1'b1; addr_ok = 1'b1; data_en = 1'b1;
    br_bus = 33'd0; force_dok = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ds_allowin = 1'b1; addr_ok = 1'b1; data_en = 1'b1;
    br_bus = 33'd0; force_dok = 1'b1;
    repeat (2) step();
    @(negedge clk);
    tests++; if (inst_sram_req !== 1'b0) begin failed++; $display("FAIL rst_req got %b exp 0", inst_sram_req); end
    tests++; if (fs_to_ds_valid !== 1'b0) begin failed++; $display("FAIL rst_valid got %b exp 0", fs_to_ds_valid); end
    tests++; if (fs_inst_cnt !== 32'd0) begin failed++; $display("FAIL rst_cnt got %0d exp 0", fs_inst_cnt); end
    tests++; if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'd2) begin failed++; $display("FAIL rst_ties got wr=%b size=%0d exp wr=0 size=2", inst_sram_wr, inst_sram_size); end
    step();
    force_dok = 1'b0; reset = 1'b0;
    @(negedge clk);
    tests++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000000) begin failed++; $display("FAIL rst_first_addr got req=%b addr=%h exp req=1 addr=1c000000", inst_sram_req, inst_sram_addr); end
    tests++; if (fs_to_ds_valid !== 1'b0) begin failed++; $display("FAIL rst_dok_discard got valid=%b exp 0", fs_to_ds_valid); end
    step();
    @(negedge clk);
    tests++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'hE3FF0000_1C000000) begin failed++; $display("FAIL rst_first_inst got valid=%b bus=%h exp 1 e3ff00001c000000", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    @(negedge clk);
    tests++; if (inst_sram_addr !== 32'h1C000000 || fs_to_ds_valid !== 1'b0) begin failed++; $display("FAIL b2b_c0 got addr=%h valid=%b exp 1c000000 0", inst_sram_addr, fs_to_ds_valid); end
    step(); @(negedge clk);
    tests++; if (inst_sram_addr !== 32'h1C000004 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'hE3FF0000_1C000000) begin failed++; $display("FAIL b2b_c1 got addr=%h valid=%b bus=%h exp 1c000004 1 e3ff00001c000000", inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus); end
    step(); @(negedge clk);
    tests++; if (inst_sram_addr !== 32'h1C000008 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'hE3FF0004_1C000004) begin failed++; $display("FAIL b2b_c2 got addr=%h valid=%b bus=%h exp 1c000008 1 e3ff00041c000004", inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_stall;
    do_reset();
    repeat (3) step();
    ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h02800421_1C000008) begin failed++; $display("FAIL stall_hold%0d got req=%b valid=%b bus=%h exp 0 1 028004211c000008", i, inst_sram_req, fs_to_ds_valid, fs_to_ds_bus); end
      step();
    end
    ds_allowin = 1'b1;
    @(negedge clk);
    tests++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h02800421_1C000008 || inst_sram_addr !== 32'h1C00000C) begin failed++; $display("FAIL stall_release got valid=%b bus=%h addr=%h exp 1 028004211c000008 1c00000c", fs_to_ds_valid, fs_to_ds_bus, inst_sram_addr); end
    step(); @(negedge clk);
    tests++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'hE3FF000C_1C00000C) begin failed++; $display("FAIL stall_nodup got valid=%b bus=%h exp 1 e3ff000c1c00000c", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_cancel;
    do_reset();
    repeat (3) step();
    data_en = 1'b0; br_bus = {1'b1, 32'h1C000100};
    @(negedge clk);
    tests++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000100 || fs_to_ds_valid !== 1'b0) begin failed++; $display("FAIL cancel_br got req=%b addr=%h valid=%b exp 1 1c000100 0", inst_sram_req, inst_sram_addr, fs_to_ds_valid); end
    step();
    br_bus = 33'd0; data_en = 1'b1;
    @(negedge clk);
    tests++; if (dut.cancel_cnt !== 2'd1 || fs_to_ds_valid !== 1'b0) begin failed++; $display("FAIL cancel_drop got cnt=%0d valid=%b exp 1 0", dut.cancel_cnt, fs_to_ds_valid); end
    step(); @(negedge clk);
    tests++; if (dut.cancel_cnt !== 2'd0 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'hE3FF0100_1C000100) begin failed++; $display("FAIL cancel_target got cnt=%0d valid=%b bus=%h exp 0 1 e3ff01001c000100", dut.cancel_cnt, fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_br_buf;
    do_reset();
    repeat (2) step();
    addr_ok = 1'b0; br_bus = {1'b1, 32'h1C000200};
    @(negedge clk);
    tests++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000200 || fs_to_ds_valid !== 1'b0) begin failed++; $display("FAIL brbuf_c0 got req=%b addr=%h valid=%b exp 1 1c000200 0", inst_sram_req, inst_sram_addr, fs_to_ds_valid); end
    step();
    br_bus = 33'd0;
    @(negedge clk);
    tests++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000200 || dut.cancel_cnt !== 2'd0) begin failed++; $display("FAIL brbuf_hold got req=%b addr=%h cnt=%0d exp 1 1c000200 0", inst_sram_req, inst_sram_addr, dut.cancel_cnt); end
    step();
    addr_ok = 1'b1;
    @(negedge clk);
    tests++; if (inst_sram_addr !== 32'h1C000200) begin failed++; $display("FAIL brbuf_accept got addr=%h exp 1c000200", inst_sram_addr); end
    step(); @(negedge clk);
    tests++; if (fs_to_ds_bus !== 64'hE3FF0200_1C000200 || inst_sram_addr !== 32'h1C000204) begin failed++; $display("FAIL brbuf_clear got bus=%h addr=%h exp e3ff02001c000200 1c000204", fs_to_ds_bus, inst_sram_addr); end
  endtask

  task automatic test_br_data;
    do_reset();
    step();
    br_bus = {1'b1, 32'h1C000300};
    @(negedge clk);
    tests++; if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'h1C000300) begin failed++; $display("FAIL brdata_c0 got valid=%b addr=%h exp 0 1c000300", fs_to_ds_valid, inst_sram_addr); end
    step();
    br_bus = 33'd0;
    @(negedge clk);
    tests++; if (dut.cancel_cnt !== 2'd0 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'hE3FF0300_1C000300) begin failed++; $display("FAIL brdata_c1 got cnt=%0d valid=%b bus=%h exp 0 1 e3ff03001c000300", dut.cancel_cnt, fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_perf;
    int n;
    logic [31:0] exp_cnt;
`ifdef FS_PERF_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    n = 0;
    do_reset();
    for (int c = 0; c < 40 && n < 10; c++) begin
      @(negedge clk);
      if (fs_to_ds_valid && ds_allowin) n++;
      if (n < 10) step();
    end
    tests++; if (n !== 10) begin failed++; $display("FAIL perf_deliveries got %0d exp 10", n); end
    step();
    ds_allowin = 1'b0;
    @(negedge clk);
    tests++; if (fs_inst_cnt !== exp_cnt) begin failed++; $display("FAIL perf_count got %0d exp %0d", fs_inst_cnt, exp_cnt); end
    reset = 1'b1;
    step(); @(negedge clk);
    tests++; if (fs_inst_cnt !== 32'd0) begin failed++; $display("FAIL perf_reset got %0d exp 0", fs_inst_cnt); end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; failed = 0;
    reset = 1'b1; ds_allowin = 1'b1; br_bus = 33'd0;
    addr_ok = 1'b1; data_en = 1'b1; force_dok = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_cancel();
    test_br_buf();
    test_br_data();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
